// File: rtl/dac_sample_scheduler_if.sv
// Sample stream between the waveform generator and the DAC scheduler.
// The generator is the master; the scheduler FIFO is the slave.
interface dac_sample_scheduler_if;
  logic [11:0] s_data;
  logic        s_valid;
  logic        s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/dac_sample_scheduler.sv
// Buffers generator samples in a FIFO and strobes one into the DAC every
// period+1 clocks, with pre-fill, start/stop control and sticky underrun.
module dac_sample_scheduler #(
  parameter int DEPTH = 8,
  parameter int DIV_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  dac_sample_scheduler_if.slave      s_if,
  input  logic [DIV_W-1:0]           div,
  input  logic                       start,
  input  logic                       stop,
  output logic [11:0]                I_data,
  output logic                       en,
  output logic                       busy,
  output logic                       underrun,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t           state_r;
  logic [DIV_W-1:0] period_r;
  logic [DIV_W-1:0] cnt_r;
  logic [11:0]      i_data_r;
  logic             en_r;
  logic             busy_r;
  logic             underrun_r;
  logic [LVL_W-1:0] level_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [11:0]      mem_r [DEPTH];

  logic             full_s;
  logic             empty_s;
  logic             ready_s;
  logic             push_s;
  logic             tick_s;
  logic             pop_s;
  logic [11:0]      head_s;

  // Handshake and tick decode; full/empty come from the registered level only.
  always_comb begin
    full_s  = (level_r == LVL_W'(DEPTH));
    empty_s = (level_r == {LVL_W{1'b0}});
    ready_s = !full_s && !stop;
    push_s  = s_if.s_valid && ready_s;
    tick_s  = (state_r == ST_RUN) && (cnt_r == period_r) && !stop;
    pop_s   = tick_s && !empty_s;
    head_s  = mem_r[rd_ptr_r];
  end

  assign s_if.s_ready = ready_s;
  assign I_data       = i_data_r;
  assign en           = en_r;
  assign busy         = busy_r;
  assign underrun     = underrun_r;
  assign level        = level_r;

  // Sample storage; contents are don't-care once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= s_if.s_data;
    end
  end

  // FIFO pointers and occupancy; stop flushes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else if (stop) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Playback state machine with registered DAC-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      period_r   <= {DIV_W{1'b0}};
      cnt_r      <= {DIV_W{1'b0}};
      i_data_r   <= 12'h800;
      en_r       <= 1'b0;
      busy_r     <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      en_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start && !stop) begin
            state_r    <= ST_PRIME;
            busy_r     <= 1'b1;
            period_r   <= div;
            underrun_r <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_PRIME: begin
          if (stop) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else if (full_s) begin
            state_r <= ST_RUN;
            cnt_r   <= {DIV_W{1'b0}};
          end else begin
            state_r <= ST_PRIME;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else if (tick_s) begin
            cnt_r <= {DIV_W{1'b0}};
            en_r  <= 1'b1;
            if (!empty_s) begin
              i_data_r <= head_s;
            end else begin
              underrun_r <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + DIV_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Directed self-checking bench for dac_sample_scheduler (DEPTH=8, DIV_W=16).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_dac_sample_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] div;
  logic        start;
  logic        stop;
  logic [11:0] I_data;
  logic        en;
  logic        busy;
  logic        underrun;
  logic [3:0]  level;

  int tests_run    = 0;
  int tests_failed = 0;

  dac_sample_scheduler_if sif ();

  dac_sample_scheduler #(.DEPTH(8), .DIV_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_if     (sif),
    .div      (div),
    .start    (start),
    .stop     (stop),
    .I_data   (I_data),
    .en       (en),
    .busy     (busy),
    .underrun (underrun),
    .level    (level)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  // Start from IDLE and push 0x000..0x777; returns at the cycle where level first reads 8.
  task automatic prime_run(input logic [15:0] d);
    div   = d;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      sif.s_valid = 1'b1;
      sif.s_data  = 12'(k * 12'h111);
      step();
    end
    sif.s_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; div = 16'd0;
    sif.s_valid = 1'b0; sif.s_data = 12'h000;
    #12;
    tests_run++; if (I_data !== 12'h800) begin tests_failed++; $display("FAIL reset_idata: got %h expected 800", I_data); end
    tests_run++; if (en !== 1'b0) begin tests_failed++; $display("FAIL reset_en: got %b expected 0", en); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests_run++; if (underrun !== 1'b0) begin tests_failed++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
    tests_run++; if (level !== 4'd0) begin tests_failed++; $display("FAIL reset_level: got %0d expected 0", level); end
    tests_run++; if (sif.s_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b expected 1", sif.s_ready); end
    step();
    rst = 1'b0;
    step();
  endtask

  // Shared expectation for div=3 playback of 0x000..0x777 at RUN cycle rc.
  task automatic check_div3(input string tag, input int rc, inout logic [11:0] exp_d);
    logic exp_en;
    logic exp_und;
    int   j;
    exp_en  = (rc >= 5) && (((rc - 5) % 4) == 0);
    j       = (rc >= 5) ? (rc - 5) / 4 : -1;
    exp_und = (j >= 8);
    if (exp_en) exp_d = (j < 8) ? 12'(j * 12'h111) : 12'h777;
    tests_run++; if (en !== exp_en) begin tests_failed++; $display("FAIL %s_en rc=%0d: got %b expected %b", tag, rc, en, exp_en); end
    tests_run++; if (I_data !== exp_d) begin tests_failed++; $display("FAIL %s_idata rc=%0d: got %h expected %h", tag, rc, I_data, exp_d); end
    tests_run++; if (underrun !== exp_und) begin tests_failed++; $display("FAIL %s_underrun rc=%0d: got %b expected %b", tag, rc, underrun, exp_und); end
    if (exp_en) begin
      tests_run++;
      if (level !== ((j < 8) ? 4'(7 - j) : 4'd0)) begin tests_failed++; $display("FAIL %s_level rc=%0d: got %0d expected %0d", tag, rc, level, (j < 8) ? 7 - j : 0); end
    end
  endtask

  logic [11:0] nom_d;

  task automatic test_nominal();
    nom_d = 12'h800;
    prime_run(16'd3);
    tests_run++; if (level !== 4'd8) begin tests_failed++; $display("FAIL nominal_prefill_level: got %0d expected 8", level); end
    tests_run++; if (busy !== 1'b1 || en !== 1'b0) begin tests_failed++; $display("FAIL nominal_prime: got busy=%b en=%b expected busy=1 en=0", busy, en); end
    for (int rc = 1; rc <= 37; rc++) begin
      step();
      check_div3("nominal", rc, nom_d);
    end
  endtask

  task automatic test_underrun();
    for (int rc = 38; rc <= 45; rc++) begin
      step();
      check_div3("underrun", rc, nom_d);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL underrun_stop_busy: got %b expected 0", busy); end
    tests_run++; if (underrun !== 1'b1) begin tests_failed++; $display("FAIL underrun_sticky_idle: got %b expected 1", underrun); end
    tests_run++; if (I_data !== 12'h777) begin tests_failed++; $display("FAIL underrun_idata_hold: got %h expected 777", I_data); end
  endtask

  task automatic test_full_rate();
    int          acc;
    int          r;
    logic        exp_en;
    logic [11:0] exp_d;
    acc = 0;
    div = 16'd0; start = 1'b1; sif.s_valid = 1'b0;
    step();
    start = 1'b0;
    tests_run++; if (underrun !== 1'b0) begin tests_failed++; $display("FAIL fullrate_underrun_cleared: got %b expected 0", underrun); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL fullrate_busy: got %b expected 1", busy); end
    for (int n = 1; n <= 30; n++) begin
      r      = n - 9;
      exp_en = (r >= 2);
      exp_d  = (r >= 2) ? 12'(12'h100 + (r - 2)) : 12'h777;
      tests_run++; if (en !== exp_en) begin tests_failed++; $display("FAIL fullrate_en n=%0d: got %b expected %b", n, en, exp_en); end
      tests_run++; if (I_data !== exp_d) begin tests_failed++; $display("FAIL fullrate_idata n=%0d: got %h expected %h", n, I_data, exp_d); end
      tests_run++; if (underrun !== 1'b0) begin tests_failed++; $display("FAIL fullrate_underrun n=%0d: got %b expected 0", n, underrun); end
      if (r >= 1) begin
        tests_run++;
        if (level !== ((r == 1) ? 4'd8 : 4'd7)) begin tests_failed++; $display("FAIL fullrate_level n=%0d: got %0d expected %0d", n, level, (r == 1) ? 8 : 7); end
      end
      sif.s_valid = 1'b1;
      sif.s_data  = 12'(12'h100 + acc);
      if (sif.s_ready) acc++;
      step();
    end
    sif.s_valid = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL fullrate_stop_busy: got %b expected 0", busy); end
  endtask

  task automatic test_stop_mid_run();
    prime_run(16'd3);
    for (int rc = 1; rc <= 14; rc++) step();
    tests_run++; if (level !== 4'd5) begin tests_failed++; $display("FAIL stop_pre_level: got %0d expected 5", level); end
    tests_run++; if (I_data !== 12'h222) begin tests_failed++; $display("FAIL stop_pre_idata: got %h expected 222", I_data); end
    stop = 1'b1; sif.s_valid = 1'b1; sif.s_data = 12'hABC;
    #1;
    tests_run++; if (sif.s_ready !== 1'b0) begin tests_failed++; $display("FAIL stop_ready: got %b expected 0", sif.s_ready); end
    step();
    stop = 1'b0; sif.s_valid = 1'b0;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL stop_busy: got %b expected 0", busy); end
    tests_run++; if (level !== 4'd0) begin tests_failed++; $display("FAIL stop_level: got %0d expected 0", level); end
    tests_run++; if (en !== 1'b0) begin tests_failed++; $display("FAIL stop_en: got %b expected 0", en); end
    tests_run++; if (I_data !== 12'h222) begin tests_failed++; $display("FAIL stop_idata: got %h expected 222", I_data); end
    step();
    tests_run++; if (level !== 4'd0 || I_data !== 12'h222) begin tests_failed++; $display("FAIL stop_idle_hold: got level=%0d data=%h expected level=0 data=222", level, I_data); end
  endtask

  task automatic test_collision_and_ignored_start();
    logic        exp_en;
    logic [11:0] exp_d;
    start = 1'b1; stop = 1'b1; div = 16'd5;
    step();
    start = 1'b0; stop = 1'b0;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL collision_busy: got %b expected 0", busy); end
    step();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL collision_stays_idle: got %b expected 0", busy); end
    exp_d = 12'h222;
    prime_run(16'd3);
    for (int rc = 1; rc <= 13; rc++) begin
      step();
      if (rc == 3) begin start = 1'b0; div = 16'd3; end
      exp_en = (rc == 5) || (rc == 9) || (rc == 13);
      if (exp_en) exp_d = 12'(((rc - 5) / 4) * 12'h111);
      tests_run++; if (en !== exp_en) begin tests_failed++; $display("FAIL ignstart_en rc=%0d: got %b expected %b", rc, en, exp_en); end
      tests_run++; if (I_data !== exp_d) begin tests_failed++; $display("FAIL ignstart_idata rc=%0d: got %h expected %h", rc, I_data, exp_d); end
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL ignstart_busy rc=%0d: got %b expected 1", rc, busy); end
      if (rc == 2) begin start = 1'b1; div = 16'd9; end
    end
  endtask

  task automatic test_async_reset();
    #2;
    rst = 1'b1;
    #1;
    tests_run++; if (I_data !== 12'h800) begin tests_failed++; $display("FAIL async_idata: got %h expected 800", I_data); end
    tests_run++; if (en !== 1'b0) begin tests_failed++; $display("FAIL async_en: got %b expected 0", en); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL async_busy: got %b expected 0", busy); end
    tests_run++; if (level !== 4'd0) begin tests_failed++; $display("FAIL async_level: got %0d expected 0", level); end
    tests_run++; if (underrun !== 1'b0) begin tests_failed++; $display("FAIL async_underrun: got %b expected 0", underrun); end
    step();
    rst = 1'b0;
    step();
    tests_run++; if (busy !== 1'b0 || level !== 4'd0) begin tests_failed++; $display("FAIL async_after: got busy=%b level=%0d expected busy=0 level=0", busy, level); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_underrun();
    test_full_rate();
    test_stop_mid_run();
    test_collision_and_ignored_start();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
